gray_counter_ctrl: RTL and testbench

GRAY_COUNTER_CTRL -- requirements
Module: gray_counter_ctrl

---
 rtl/gray_counter_ctrl.sv | 141 ++++++++++++++
 tb/tb_gray_counter_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gray_counter_ctrl
// Purpose  : Configurable binary/Gray up-counter with a four-state run
//            controller (IDLE, RUN, PAUSE, DONE). The counter runs from 0 up to
//            a latched terminal count and then either stops (one-shot) or
//            wraps back to 0 (continuous).
// Ports    : clk, rst          - clock, synchronous active-high reset
//            cfg_valid/ready   - configuration handshake (accepted in IDLE/DONE)
//            cfg_limit         - binary terminal count
//            cfg_mode          - 0 = one-shot, 1 = continuous wrap
//            start/pause/stop  - run control (pause is a level)
//            bin_count         - registered binary count
//            gray_count        - registered Gray code of bin_count
//            busy              - high in RUN or PAUSE
//            done / wrap       - one-cycle completion / wrap pulses
//            state             - IDLE=00, RUN=01, PAUSE=10, DONE=11
// Revision : 1.0 - initial release
// ============================================================================
module gray_counter_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] bin_count,
    output logic [WIDTH-1:0] gray_count,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;

    state_t           state_q;
    logic [WIDTH-1:0] limit_q;
    logic             mode_q;

    // Gray encoding is applied to the value being written so that
    // bin_count and gray_count always update on the same edge.
    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Status outputs depend on the registered state only.
    assign state     = state_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bin_count  <= CNT_ZERO;
            gray_count <= CNT_ZERO;
            done       <= 1'b0;
            wrap       <= 1'b0;
            limit_q    <= CNT_MAX;
            mode_q     <= 1'b1;
        end else begin
            // Pulses last exactly one cycle unless re-asserted below.
            done <= 1'b0;
            wrap <= 1'b0;

            // Configuration is only taken while the controller is idle or
            // finished; a request during a run is dropped, not queued.
            if (cfg_valid && cfg_ready) begin
                limit_q <= cfg_limit;
                mode_q  <= cfg_mode;
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // stop is meaningless here; bin_count holds until start.
                    if (start) begin
                        state_q    <= ST_RUN;
                        bin_count  <= CNT_ZERO;
                        gray_count <= CNT_ZERO;
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        state_q    <= ST_IDLE;
                        bin_count  <= CNT_ZERO;
                        gray_count <= CNT_ZERO;
                    end else if (pause) begin
                        state_q <= ST_PAUSE;
                    end else if (bin_count == limit_q) begin
                        if (mode_q) begin
                            // Continuous: restart at 0; with limit 0 this
                            // holds 0 and wraps every RUN cycle.
                            bin_count  <= CNT_ZERO;
                            gray_count <= CNT_ZERO;
                            wrap       <= 1'b1;
                        end else begin
                            // One-shot: park at the terminal count.
                            state_q <= ST_DONE;
                            done    <= 1'b1;
                        end
                    end else begin
                        bin_count  <= bin_count + CNT_ONE;
                        gray_count <= to_gray(bin_count + CNT_ONE);
                    end
                end

                ST_PAUSE: begin
                    if (stop) begin
                        state_q    <= ST_IDLE;
                        bin_count  <= CNT_ZERO;
                        gray_count <= CNT_ZERO;
                    end else if (!pause) begin
                        // Resume without counting on the resume edge.
                        state_q <= ST_RUN;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gray_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_counter_ctrl
// Purpose  : Directed self-checking bench for gray_counter_ctrl (WIDTH = 3).
//            Expected values are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_counter_ctrl;

    localparam int WIDTH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_limit;
    logic             cfg_mode;
    logic             start;
    logic             pause;
    logic             stop;
    logic [WIDTH-1:0] bin_count;
    logic [WIDTH-1:0] gray_count;
    logic             busy;
    logic             done;
    logic             wrap;
    logic [1:0]       state;

    int n_checks = 0;
    int n_fail   = 0;

    // Gray codes of 0..7, written out by hand.
    int gtab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    gray_counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_limit  (cfg_limit),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .pause      (pause),
        .stop       (stop),
        .bin_count  (bin_count),
        .gray_count (gray_count),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Full output check; busy and cfg_ready follow from the expected state.
    task automatic expect_all(input string tag, input int st, input int bin,
                              input int dn, input int wr);
        check({tag, ".state"}, int'(state), st);
        check({tag, ".bin"}, int'(bin_count), bin);
        check({tag, ".gray"}, int'(gray_count), gtab[bin]);
        check({tag, ".done"}, int'(done), dn);
        check({tag, ".wrap"}, int'(wrap), wr);
        check({tag, ".busy"}, int'(busy), (st == S_RUN || st == S_PAUSE) ? 1 : 0);
        check({tag, ".cfg_ready"}, int'(cfg_ready), (st == S_IDLE || st == S_DONE) ? 1 : 0);
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input int lim, input logic md);
        cfg_valid = 1'b1;
        cfg_limit = WIDTH'(lim);
        cfg_mode  = md;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_limit = '0; cfg_mode = 1'b0;
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        expect_all("reset", S_IDLE, 0, 0, 0);

        // Default config (limit 7, continuous): full Gray cycle, wrap on 0 after 7.
        do_start();
        expect_all("def_start", S_RUN, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            expect_all($sformatf("def_cnt%0d", i), S_RUN, i % 8, 0, (i == 8) ? 1 : 0);
        end
        stop = 1'b1; tick(); stop = 1'b0;
        expect_all("def_stop", S_IDLE, 0, 0, 0);

        // One-shot to 4: DONE holds gray 110, single done pulse.
        configure(4, 1'b0);
        expect_all("os_cfg", S_IDLE, 0, 0, 0);
        do_start();
        expect_all("os_start", S_RUN, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            expect_all($sformatf("os_cnt%0d", i), S_RUN, i, 0, 0);
        end
        tick();
        expect_all("os_done", S_DONE, 4, 1, 0);
        tick();
        expect_all("os_hold", S_DONE, 4, 0, 0);
        configure(7, 1'b0);
        expect_all("done_cfg", S_DONE, 4, 0, 0);
        stop = 1'b1; tick(); stop = 1'b0;
        expect_all("done_stop", S_DONE, 4, 0, 0);

        // Pause for three cycles at bin 2 (limit 7, one-shot).
        do_start();
        tick(); tick();
        expect_all("p_pre", S_RUN, 2, 0, 0);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_all($sformatf("p_hold%0d", i), S_PAUSE, 2, 0, 0);
        end
        pause = 1'b0;
        tick();
        expect_all("p_resume", S_RUN, 2, 0, 0);
        tick();
        expect_all("p_next", S_RUN, 3, 0, 0);
        start = 1'b1; tick(); start = 1'b0;
        expect_all("run_start_ign", S_RUN, 4, 0, 0);
        tick();
        expect_all("at5", S_RUN, 5, 0, 0);

        // cfg during RUN is refused; stop beats pause.
        cfg_valid = 1'b1; cfg_limit = 3'd2; cfg_mode = 1'b1;
        #1;
        check("run_cfg_ready", int'(cfg_ready), 0);
        stop = 1'b1; pause = 1'b1;
        tick();
        stop = 1'b0; pause = 1'b0; cfg_valid = 1'b0;
        expect_all("stop_pause", S_IDLE, 0, 0, 0);

        // Limit must still be 7 one-shot: count to 7 then DONE.
        do_start();
        for (int i = 1; i <= 7; i++) begin
            tick();
            expect_all($sformatf("lim_kept%0d", i), S_RUN, i, 0, 0);
        end
        tick();
        expect_all("lim_kept_done", S_DONE, 7, 1, 0);

        // Config in same cycle as start governs the run; reset at bin 6.
        cfg_valid = 1'b1; cfg_limit = 3'd7; cfg_mode = 1'b1; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        expect_all("cs_start", S_RUN, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        expect_all("at6", S_RUN, 6, 0, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        expect_all("mid_reset", S_IDLE, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("post_rst_done%0d", i), int'(done), 0);
            check($sformatf("post_rst_wrap%0d", i), int'(wrap), 0);
        end

        // Limit 0 continuous: hold 0, wrap every RUN cycle after start.
        configure(0, 1'b1);
        do_start();
        expect_all("z_start", S_RUN, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_all($sformatf("z_wrap%0d", i), S_RUN, 0, 0, 1);
        end

        // Stop from PAUSE, then limit 0 one-shot completes on first RUN cycle.
        pause = 1'b1; tick(); pause = 1'b0;
        check("z_pause_state", int'(state), S_PAUSE);
        stop = 1'b1; pause = 1'b1; tick(); stop = 1'b0; pause = 1'b0;
        expect_all("pause_stop", S_IDLE, 0, 0, 0);
        cfg_valid = 1'b1; cfg_limit = 3'd0; cfg_mode = 1'b0; start = 1'b1;
        tick();
        cfg_valid = 1'b0; start = 1'b0;
        expect_all("z_os_start", S_RUN, 0, 0, 0);
        tick();
        expect_all("z_os_done", S_DONE, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
